// File: rtl/spart_word_ctrl_pkg.sv
// Shared definitions for the SPART 16-bit word controller: state encodings,
// byte-select constants, the timeout fill word and small byte helpers.
package spart_word_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TX_B0 = 3'd1,
        ST_TX_B1 = 3'd2,
        ST_RX_B0 = 3'd3,
        ST_RX_B1 = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic BYTE_HI = 1'b1;
    localparam logic BYTE_LO = 1'b0;

    localparam logic [15:0] RX_TIMEOUT_WORD = 16'hFFFF;

    // GAP_CYCLES is limited to 1..15, so the gap count always fits in 4 bits
    localparam int unsigned GAP_TMR_W = 4;

    // Which half of the word is moved in a given transfer slot (second=0 is B0)
    function automatic logic byte_of(input logic hi_first, input logic second);
        return (hi_first ^ second) ? BYTE_HI : BYTE_LO;
    endfunction

    // Replace one byte of a word, leaving the other half untouched
    function automatic logic [15:0] place_byte(input logic [15:0] word,
                                               input logic        sel,
                                               input logic [7:0]  b);
        logic [15:0] w;
        w = word;
        if (sel == BYTE_HI) begin
            w[15:8] = b;
        end else begin
            w[7:0] = b;
        end
        return w;
    endfunction

endpackage

// File: rtl/spart_wait_timer.sv
// Loadable down-counter shared by the inter-strobe gap and the byte-wait watchdog.
// load has priority over en; the count saturates at zero.
module spart_wait_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, or step down while not yet at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/spart_word_ctrl.sv
// Sequences 16-bit word transfers over the 8-bit SPART byte interface:
// byte-select, write/read strobes, pipeline stall and receive word assembly.
// Optional build macro SPART_TIMEOUT_EN adds a per-byte watchdog that aborts
// a transfer stuck waiting on tbr/rda; without it the controller waits forever.
module spart_word_ctrl
    import spart_word_ctrl_pkg::*;
#(
    parameter int unsigned HI_FIRST       = 1,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_req,
    input  logic        rx_req,
    output logic        stall,
    output logic        byte_sel,
    input  logic        spart_tbr,
    output logic        spart_wr,
    input  logic        spart_rda,
    output logic        spart_rd,
    input  logic [7:0]  spart_rx_byte,
    output logic [15:0] rx_word,
    output logic        rx_valid,
    output logic        timeout
);

    localparam logic HI = (HI_FIRST != 0);

`ifdef SPART_TIMEOUT_EN
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TMR_W = (TO_W > GAP_TMR_W) ? TO_W : GAP_TMR_W;
    localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`else
    localparam int unsigned TMR_W = GAP_TMR_W;
`endif
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

    // Reject configurations the counters cannot represent
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("spart_word_ctrl: GAP_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 2");
    end

    state_e      state_q, state_d;
    logic        phase_q, phase_d;     // 0: first byte (and its gap), 1: second
    logic        is_rx_q, is_rx_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] rx_word_q, rx_word_d;
`ifdef SPART_TIMEOUT_EN
    logic        to_q, to_d;
`endif

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_zero;

    logic             cur_second;

    spart_wait_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero_c   (tmr_zero)
    );

    assign cur_second = (state_q == ST_TX_B1) || (state_q == ST_RX_B1);

    // Next-state, strobes, stall, byte select and receive assembly
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        is_rx_d   = is_rx_q;
        shadow_d  = shadow_q;
        rx_word_d = rx_word_q;
`ifdef SPART_TIMEOUT_EN
        to_d      = to_q;
`endif
        tmr_load  = 1'b0;
        tmr_val   = GAP_LOAD;
        tmr_en    = 1'b0;
        stall     = 1'b0;
        byte_sel  = BYTE_LO;
        spart_wr  = 1'b0;
        spart_rd  = 1'b0;
        rx_valid  = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall   = tx_req | rx_req;
                phase_d = 1'b0;
`ifdef SPART_TIMEOUT_EN
                to_d    = 1'b0;
                tmr_val = TO_LOAD;
`endif
                if (tx_req) begin
                    state_d  = ST_TX_B0;
                    is_rx_d  = 1'b0;
                    tmr_load = 1'b1;
                end else if (rx_req) begin
                    state_d  = ST_RX_B0;
                    is_rx_d  = 1'b1;
                    tmr_load = 1'b1;
                end
            end

            ST_TX_B0, ST_TX_B1: begin
                stall    = 1'b1;
                byte_sel = byte_of(HI, cur_second);
                if (spart_tbr) begin
                    spart_wr = 1'b1;
                    phase_d  = cur_second;
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
`ifdef SPART_TIMEOUT_EN
                end else if (tmr_zero) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
`endif
                end
            end

            ST_RX_B0, ST_RX_B1: begin
                stall = 1'b1;
                if (spart_rda) begin
                    spart_rd = 1'b1;
                    shadow_d = place_byte(shadow_q, byte_of(HI, cur_second), spart_rx_byte);
                    phase_d  = cur_second;
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
`ifdef SPART_TIMEOUT_EN
                end else if (tmr_zero) begin
                    state_d   = ST_DONE;
                    to_d      = 1'b1;
                    rx_word_d = RX_TIMEOUT_WORD;
                end else begin
                    tmr_en = 1'b1;
`endif
                end
            end

            ST_GAP: begin
                stall    = 1'b1;
                byte_sel = is_rx_q ? BYTE_LO : byte_of(HI, phase_q);
                if (tmr_zero) begin
                    if (phase_q) begin
                        state_d = ST_DONE;
                        if (is_rx_q) begin
                            rx_word_d = shadow_q;
                        end
                    end else begin
                        state_d = is_rx_q ? ST_RX_B1 : ST_TX_B1;
`ifdef SPART_TIMEOUT_EN
                        tmr_load = 1'b1;
                        tmr_val  = TO_LOAD;
`endif
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_DONE: begin
                rx_valid = is_rx_q;
`ifdef SPART_TIMEOUT_EN
                timeout  = to_q;
`endif
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A reset cycle never stalls or strobes, whatever state it interrupts
        if (rst) begin
            stall    = 1'b0;
            byte_sel = BYTE_LO;
            spart_wr = 1'b0;
            spart_rd = 1'b0;
            rx_valid = 1'b0;
            timeout  = 1'b0;
        end
    end

    // State and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            is_rx_q   <= 1'b0;
            shadow_q  <= 16'h0000;
            rx_word_q <= 16'h0000;
`ifdef SPART_TIMEOUT_EN
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            is_rx_q   <= is_rx_d;
            shadow_q  <= shadow_d;
            rx_word_q <= rx_word_d;
`ifdef SPART_TIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

    assign rx_word = rx_word_q;

endmodule

// File: tb/tb_spart_word_ctrl.sv
// Bench for spart_word_ctrl. Two instances: A (high byte first, 1 gap cycle,
// 16-cycle watchdog) and B (low byte first, 3 gap cycles, 8-cycle watchdog).
// Each transfer is expanded into a per-cycle timeline of inputs and required
// outputs from the transfer rules, then played against one instance.
module tb_spart_word_ctrl;

    localparam int unsigned GA  = 1;
    localparam int unsigned GB  = 3;
    localparam int unsigned TOA = 16;
    localparam int unsigned TOB = 8;
`ifdef SPART_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       tx_req;
        logic       rx_req;
        logic       tbr;
        logic       rda;
        logic [7:0] rx_byte;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        byte_sel;
        logic        wr;
        logic        rd;
        logic        rx_valid;
        logic        timeout;
        logic [15:0] rx_word;
    } outv_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_tx_req, a_rx_req, a_tbr, a_rda;
    logic [7:0]  a_rx_byte;
    logic        a_stall, a_byte_sel, a_wr, a_rd, a_rx_valid, a_timeout;
    logic [15:0] a_rx_word;
    logic        b_rst, b_tx_req, b_rx_req, b_tbr, b_rda;
    logic [7:0]  b_rx_byte;
    logic        b_stall, b_byte_sel, b_wr, b_rd, b_rx_valid, b_timeout;
    logic [15:0] b_rx_word;

    spart_word_ctrl #(.HI_FIRST(1), .GAP_CYCLES(GA), .TIMEOUT_CYCLES(TOA)) dut_a (
        .clk(clk), .rst(a_rst), .tx_req(a_tx_req), .rx_req(a_rx_req),
        .stall(a_stall), .byte_sel(a_byte_sel), .spart_tbr(a_tbr), .spart_wr(a_wr),
        .spart_rda(a_rda), .spart_rd(a_rd), .spart_rx_byte(a_rx_byte),
        .rx_word(a_rx_word), .rx_valid(a_rx_valid), .timeout(a_timeout)
    );

    spart_word_ctrl #(.HI_FIRST(0), .GAP_CYCLES(GB), .TIMEOUT_CYCLES(TOB)) dut_b (
        .clk(clk), .rst(b_rst), .tx_req(b_tx_req), .rx_req(b_rx_req),
        .stall(b_stall), .byte_sel(b_byte_sel), .spart_tbr(b_tbr), .spart_wr(b_wr),
        .spart_rda(b_rda), .spart_rd(b_rd), .spart_rx_byte(b_rx_byte),
        .rx_word(b_rx_word), .rx_valid(b_rx_valid), .timeout(b_timeout)
    );

    stim_t       stim_q[$];
    outv_t       want_q[$];
    logic [15:0] mword [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic stim_t noise();
        stim_t s;
        s.rst     = 1'b0;
        s.tx_req  = 1'b0;
        s.rx_req  = 1'b0;
        s.tbr     = 1'($urandom_range(0, 1));
        s.rda     = 1'($urandom_range(0, 1));
        s.rx_byte = 8'($urandom);
        return s;
    endfunction

    function automatic outv_t quiet(input int d);
        outv_t o;
        o = '0;
        o.rx_word = mword[d];
        return o;
    endfunction

    // Byte select for slot n: slot 0 is the high byte when high-first
    function automatic logic sel_of(input bit hi, input int n);
        return hi ? (n == 0) : (n == 1);
    endfunction

    task automatic push(input stim_t s, input outv_t o);
        stim_q.push_back(s);
        want_q.push_back(o);
    endtask

    task automatic add_idle(input int d, input int n);
        for (int i = 0; i < n; i++) push(noise(), quiet(d));
    endtask

    // One word transfer: dl0/dl1 are cycles tbr/rda stays low before each byte
    task automatic add_xfer(input int d, input bit is_rx, input bit both,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input int dl0, input int dl1);
        bit          hi, ab;
        int          g, to, nw;
        int          dl[2];
        logic [7:0]  bs[2];
        stim_t       s;
        outv_t       o;
        hi = (d == 0);
        g  = (d == 0) ? GA : GB;
        to = (d == 0) ? TOA : TOB;
        ab = 1'b0;
        dl[0] = dl0; dl[1] = dl1;
        bs[0] = b0;  bs[1] = b1;

        s = noise(); s.tx_req = !is_rx || both; s.rx_req = is_rx || both;
        o = quiet(d); o.stall = 1'b1;
        push(s, o);
        for (int n = 0; n < 2; n++) begin
            if (!ab) begin
                nw = (TO_EN && dl[n] >= to) ? to : dl[n];
                for (int k = 0; k < nw; k++) begin
                    s = noise(); s.tx_req = !is_rx || both; s.rx_req = is_rx || both;
                    if (is_rx) s.rda = 1'b0; else s.tbr = 1'b0;
                    o = quiet(d); o.stall = 1'b1; o.byte_sel = is_rx ? 1'b0 : sel_of(hi, n);
                    push(s, o);
                end
                if (TO_EN && dl[n] >= to) begin
                    ab = 1'b1;
                end else begin
                    s = noise(); s.tx_req = !is_rx || both; s.rx_req = is_rx || both;
                    if (is_rx) begin s.rda = 1'b1; s.rx_byte = bs[n]; end else s.tbr = 1'b1;
                    o = quiet(d); o.stall = 1'b1; o.byte_sel = is_rx ? 1'b0 : sel_of(hi, n);
                    o.wr = !is_rx; o.rd = is_rx;
                    push(s, o);
                    for (int k = 0; k < g; k++) begin
                        s = noise(); s.tx_req = !is_rx || both; s.rx_req = is_rx || both;
                        o = quiet(d); o.stall = 1'b1; o.byte_sel = is_rx ? 1'b0 : sel_of(hi, n);
                        push(s, o);
                    end
                end
            end
        end
        s = noise(); s.tx_req = !is_rx || both; s.rx_req = is_rx || both;
        if (is_rx) mword[d] = ab ? 16'hFFFF : (hi ? {b0, b1} : {b1, b0});
        o = quiet(d); o.rx_valid = is_rx; o.timeout = ab;
        push(s, o);
    endtask

    // Reset mid-TX: at_strobe=1 hits TX_B0 with tbr high, else the first gap cycle
    task automatic add_rst(input int d, input bit at_strobe);
        stim_t s;
        outv_t o;
        s = noise(); s.tx_req = 1'b1; s.rx_req = 1'b0;
        o = quiet(d); o.stall = 1'b1;
        push(s, o);
        if (!at_strobe) begin
            s = noise(); s.tx_req = 1'b1; s.tbr = 1'b1;
            o = quiet(d); o.stall = 1'b1; o.wr = 1'b1; o.byte_sel = sel_of(d == 0, 0);
            push(s, o);
        end
        s = noise(); s.tx_req = 1'b1; s.tbr = 1'b1; s.rst = 1'b1;
        push(s, quiet(d));
        mword[d] = 16'h0000;
        s = noise(); s.tbr = 1'b1;
        push(s, quiet(d));
        add_idle(d, 1);
    endtask

    task automatic drive(input int d, input stim_t s);
        if (d == 0) begin
            a_rst = s.rst; a_tx_req = s.tx_req; a_rx_req = s.rx_req;
            a_tbr = s.tbr; a_rda = s.rda; a_rx_byte = s.rx_byte;
        end else begin
            b_rst = s.rst; b_tx_req = s.tx_req; b_rx_req = s.rx_req;
            b_tbr = s.tbr; b_rda = s.rda; b_rx_byte = s.rx_byte;
        end
    endtask

    // Play the queued timeline on one instance, comparing every cycle
    task automatic run(input int d);
        stim_t s;
        outv_t w, g;
        int    cyc;
        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            w = want_q.pop_front();
            @(posedge clk); #1;
            drive(d, s);
            @(negedge clk);
            if (d == 0) begin
                g.stall = a_stall; g.byte_sel = a_byte_sel; g.wr = a_wr; g.rd = a_rd;
                g.rx_valid = a_rx_valid; g.timeout = a_timeout; g.rx_word = a_rx_word;
            end else begin
                g.stall = b_stall; g.byte_sel = b_byte_sel; g.wr = b_wr; g.rd = b_rd;
                g.rx_valid = b_rx_valid; g.timeout = b_timeout; g.rx_word = b_rx_word;
            end
            checks++;
            if (g !== w) begin
                errors++;
                $display("FAIL outputs dut%0d cyc%0d got stall/sel/wr/rd/vld/to=%b%b%b%b%b%b word=%h want %b%b%b%b%b%b word=%h",
                         d, cyc, g.stall, g.byte_sel, g.wr, g.rd, g.rx_valid, g.timeout, g.rx_word,
                         w.stall, w.byte_sel, w.wr, w.rd, w.rx_valid, w.timeout, w.rx_word);
            end
            cyc++;
        end
        @(posedge clk); #1;
        drive(d, '0);
    endtask

    function automatic int count_field(input int which);
        int c;
        c = 0;
        foreach (want_q[i]) begin
            case (which)
                0: c += int'(want_q[i].stall);
                1: c += int'(want_q[i].rd);
                default: c += int'(want_q[i].rx_valid);
            endcase
        end
        return c;
    endfunction

    function automatic int rand_dly();
        return ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        drive(0, '0); drive(1, '0);
        a_rst = 1'b1; b_rst = 1'b1;
        mword[0] = 16'h0000; mword[1] = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_word_a", 32'(a_rx_word), 32'h0);
        chk("reset_rx_word_b", 32'(b_rx_word), 32'h0);
        chk("reset_outs_a", 32'({a_stall, a_byte_sel, a_wr, a_rd, a_rx_valid, a_timeout}), 32'h0);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;

        // TX word, high byte first, no waits
        add_xfer(0, 1'b0, 1'b0, 8'hA5, 8'h5A, 0, 0);
        chk("t1_len", 32'(want_q.size()), 32'd6);
        chk("t1_wr1", 32'({want_q[1].wr, want_q[1].byte_sel}), 32'b11);
        chk("t1_wr3", 32'({want_q[3].wr, want_q[3].byte_sel}), 32'b10);
        chk("t1_stall_cycles", 32'(count_field(0)), 32'd5);
        run(0);

        // RX with 10-cycle rda delays
        add_xfer(0, 1'b1, 1'b0, 8'h12, 8'h34, 10, 10);
        chk("t2_model_word", 32'(want_q[want_q.size()-1].rx_word), 32'h1234);
        chk("t2_valid_count", 32'(count_field(2)), 32'd1);
        run(0);
        chk("t2_rx_word", 32'(a_rx_word), 32'h1234);

        // Simultaneous requests: TX only
        add_xfer(0, 1'b0, 1'b1, 8'h00, 8'h00, 1, 2);
        chk("t4_no_rd", 32'(count_field(1)), 32'd0);
        run(0);
        chk("t4_rx_word_kept", 32'(a_rx_word), 32'h1234);

        // Reset in the gap after the first TX byte, then in TX_B0 with tbr high
        add_rst(0, 1'b0);
        add_rst(0, 1'b1);
        run(0);
        chk("t5_rx_word", 32'(a_rx_word), 32'h0);

        // Low byte first receive
        add_xfer(1, 1'b1, 1'b0, 8'h12, 8'h34, 2, 1);
        chk("t3_model_word", 32'(want_q[want_q.size()-1].rx_word), 32'h3412);
        run(1);
        chk("t3_rx_word", 32'(b_rx_word), 32'h3412);

`ifdef SPART_TIMEOUT_EN
        // Watchdog abort on a receive that never sees rda
        add_xfer(1, 1'b1, 1'b0, 8'h00, 8'h00, 20, 0);
        chk("t6_len", 32'(want_q.size()), 32'd10);
        chk("t6_model_word", 32'(want_q[want_q.size()-1].rx_word), 32'hFFFF);
        run(1);
        chk("t6_rx_word", 32'(b_rx_word), 32'hFFFF);
`endif

        // Randomized mix on both instances
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 30; t++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: add_xfer(d, 1'b0, 1'b0, 8'h00, 8'h00, rand_dly(), rand_dly());
                    3, 4, 5, 6: add_xfer(d, 1'b1, 1'b0, 8'($urandom), 8'($urandom), rand_dly(), rand_dly());
                    7: add_xfer(d, 1'b0, 1'b1, 8'h00, 8'h00, rand_dly(), rand_dly());
                    8: add_rst(d, 1'($urandom_range(0, 1)));
                    default: add_idle(d, 3);
                endcase
                add_idle(d, int'($urandom_range(0, 2)));
            end
            run(d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
